// File: rtl/slv_guard_rst_seq.sv
// Reset sequencer for the guarded subordinate: isolate, drain (bounded), hold reset, release and ack.
// Tracks outstanding reads/writes from subordinate-side handshake strobes.
module slv_guard_rst_seq #(
  parameter int MaxOutstanding = 8,
  parameter int DrainTimeout   = 256,
  parameter int RstHold        = 16,
  parameter int CntWidth       = 16,
  localparam int OutW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            rst_req_i,
  // Each *_hs_i is a completed beat: valid & ready (& last for R) sampled on
  // the same rising edge; one strobe counts as exactly one handshake.
  input  logic            aw_hs_i,
  input  logic            b_hs_i,
  input  logic            ar_hs_i,
  input  logic            r_last_hs_i,
  output logic            isolate_o,
  output logic            slv_rst_no,
  output logic            rst_ack_o,
  output logic            busy_o,
  output logic            forced_o,
  output logic            proto_err_o,
  output logic [OutW-1:0] wr_out_o,
  output logic [OutW-1:0] rd_out_o,
  output logic [1:0]      state_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISOLATE = 2'd1;
  localparam logic [1:0] S_RESET   = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [CntWidth-1:0] DrainLast = CntWidth'(DrainTimeout - 1);
  localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(RstHold - 1);
  localparam logic [OutW-1:0]     MaxCnt    = OutW'(MaxOutstanding);

  logic [1:0]          state;
  logic [1:0]          state_n;
  logic [CntWidth-1:0] drain_cnt;
  logic [CntWidth-1:0] hold_cnt;
  logic                drained;
  logic [OutW:0]       wr_step;
  logic [OutW:0]       rd_step;

  // Returns {error, next_count}; simultaneous inc/dec cancel out.
  function automatic logic [OutW:0] cnt_step(input logic [OutW-1:0] cnt,
                                             input logic inc, input logic dec);
    logic [OutW:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == MaxCnt) res[OutW] = 1'b1;
      else               res = {1'b0, cnt + OutW'(1)};
    end else if (dec && !inc) begin
      if (cnt == '0) res[OutW] = 1'b1;
      else           res = {1'b0, cnt - OutW'(1)};
    end
    return res;
  endfunction

  assign state_o = state;
  assign drained = (wr_out_o == '0) && (rd_out_o == '0);
  assign wr_step = cnt_step(wr_out_o, aw_hs_i, b_hs_i);
  assign rd_step = cnt_step(rd_out_o, ar_hs_i, r_last_hs_i);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (rst_req_i) state_n = S_ISOLATE;
      S_ISOLATE: if (drained || drain_cnt == DrainLast) state_n = S_RESET;
      S_RESET:   if (hold_cnt == HoldLast) state_n = S_RELEASE;
      S_RELEASE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      hold_cnt    <= '0;
      isolate_o   <= 1'b0;
      slv_rst_no  <= 1'b1;
      rst_ack_o   <= 1'b0;
      busy_o      <= 1'b0;
      forced_o    <= 1'b0;
      proto_err_o <= 1'b0;
      wr_out_o    <= '0;
      rd_out_o    <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= (state == S_ISOLATE) ? drain_cnt + CntWidth'(1) : '0;
      hold_cnt  <= (state == S_RESET) ? hold_cnt + CntWidth'(1) : '0;

      // Outputs are registered from the next state so they line up with it.
      isolate_o  <= (state_n != S_IDLE);
      busy_o     <= (state_n != S_IDLE);
      slv_rst_no <= (state_n != S_RESET);
      rst_ack_o  <= (state_n == S_RELEASE);

      if (state == S_ISOLATE && state_n == S_RESET) forced_o <= !drained;

      // Handshakes on the edge into RESET are dropped along with the counts.
      if (state == S_RESET || state_n == S_RESET) begin
        wr_out_o <= '0;
        rd_out_o <= '0;
      end else begin
        wr_out_o    <= wr_step[OutW-1:0];
        rd_out_o    <= rd_step[OutW-1:0];
        proto_err_o <= proto_err_o | wr_step[OutW] | rd_step[OutW];
      end
    end
  end

endmodule

// File: tb/tb_slv_guard_rst_seq.sv
// Bench for slv_guard_rst_seq: directed and random traffic against a count/saturation model,
// with a monitor that checks each reset sequence against queued expectations.
module tb_slv_guard_rst_seq;

  localparam int MAX_OUT       = 8;
  localparam int DRAIN_TIMEOUT = 256;
  localparam int RST_HOLD      = 16;
  localparam int OW            = $clog2(MAX_OUT + 1);

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rst_req = 1'b0;
  logic          aw_hs = 1'b0;
  logic          b_hs = 1'b0;
  logic          ar_hs = 1'b0;
  logic          r_last_hs = 1'b0;
  logic          isolate, slv_rst_n, rst_ack, busy, forced, proto_err;
  logic [OW-1:0] wr_out, rd_out;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: outstanding counts and sticky error as plain integers.
  int wr_model = 0;
  int rd_model = 0;
  bit perr_model = 1'b0;

  // Expected sequence: {forced, isolate_length[15:0]}.
  logic [16:0] exp_q[$];

  int iso_cnt = 0;
  int hold_cnt = 0;
  int busy_cnt = 0;
  bit after_ack = 1'b0;

  slv_guard_rst_seq #(
    .MaxOutstanding(MAX_OUT),
    .DrainTimeout  (DRAIN_TIMEOUT),
    .RstHold       (RST_HOLD),
    .CntWidth      (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rst_req_i  (rst_req),
    .aw_hs_i    (aw_hs),
    .b_hs_i     (b_hs),
    .ar_hs_i    (ar_hs),
    .r_last_hs_i(r_last_hs),
    .isolate_o  (isolate),
    .slv_rst_no (slv_rst_n),
    .rst_ack_o  (rst_ack),
    .busy_o     (busy),
    .forced_o   (forced),
    .proto_err_o(proto_err),
    .wr_out_o   (wr_out),
    .rd_out_o   (rd_out),
    .state_o    (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(inout int cnt, inout bit perr, input bit inc, input bit dec);
    if (inc && !dec) begin
      if (cnt == MAX_OUT) perr = 1'b1;
      else cnt++;
    end else if (dec && !inc) begin
      if (cnt == 0) perr = 1'b1;
      else cnt--;
    end
  endtask

  // driver tasks
  task automatic hs(input bit aw, input bit b, input bit ar, input bit r);
    aw_hs = aw; b_hs = b; ar_hs = ar; r_last_hs = r;
    model_step(wr_model, perr_model, aw, b);
    model_step(rd_model, perr_model, ar, r);
    tick();
    aw_hs = 1'b0; b_hs = 1'b0; ar_hs = 1'b0; r_last_hs = 1'b0;
    check("wr_out", int'(wr_out), wr_model);
    check("rd_out", int'(rd_out), rd_model);
    check("proto_err", int'(proto_err), int'(perr_model));
  endtask

  task automatic req_pulse(input int iso_len, input bit exp_forced);
    exp_q.push_back({exp_forced, 16'(iso_len)});
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
  endtask

  task automatic wait_ack(input bit drop_req);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (rst_ack) seen = 1'b1;
      else tick();
    end
    check("ack_seen", int'(seen), 1);
    if (drop_req) rst_req = 1'b0;
    tick();
    wr_model = 0;
    rd_model = 0;
  endtask

  // scoreboard monitor: one expected entry per acknowledged sequence
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst_ni) begin
      iso_cnt = 0; hold_cnt = 0; busy_cnt = 0; after_ack = 1'b0;
    end else begin
      if (after_ack) begin
        check("post_ack_quiet", int'({rst_ack, isolate, busy}), 0);
        after_ack = 1'b0;
      end
      if (busy) busy_cnt++;
      if (isolate && slv_rst_n && !rst_ack) iso_cnt++;
      if (!slv_rst_n) hold_cnt++;
      if (rst_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("isolate_len", iso_cnt, int'(e[15:0]));
          check("hold_len", hold_cnt, RST_HOLD);
          check("busy_len", busy_cnt, int'(e[15:0]) + RST_HOLD + 1);
          check("forced", int'(forced), int'(e[16]));
          check("rst_high_on_ack", int'(slv_rst_n), 1);
          check("counts_on_ack", int'(wr_out) + int'(rd_out), 0);
        end
        iso_cnt = 0; hold_cnt = 0; busy_cnt = 0; after_ack = 1'b1;
      end
    end
  end

  initial begin
    bit resp[5];
    int j;
    bit tmp;
    int exp_iso;

    // reset state
    repeat (3) tick();
    check("rst_isolate", int'(isolate), 0);
    check("rst_slv_rst_n", int'(slv_rst_n), 1);
    check("rst_ack", int'(rst_ack), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_forced", int'(forced), 0);
    check("rst_proto_err", int'(proto_err), 0);
    check("rst_counts", int'(wr_out) + int'(rd_out), 0);
    check("rst_state", int'(state), 0);
    rst_ni = 1'b1;
    tick();

    // idle request: ISOLATE 1, RESET 16, busy 18
    req_pulse(1, 1'b0);
    check("isolate_rise", int'(isolate), 1);
    check("busy_rise", int'(busy), 1);
    wait_ack(1'b0);

    // drain: 3 writes, 2 reads, responses every 4 cycles in random order
    repeat (3) hs(1, 0, 0, 0);
    repeat (2) hs(0, 0, 1, 0);
    resp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 4; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = resp[i]; resp[i] = resp[j]; resp[j] = tmp;
    end
    exp_iso = 4 * 4 + 2;
    req_pulse(exp_iso < DRAIN_TIMEOUT ? exp_iso : DRAIN_TIMEOUT, 1'b0);
    for (int i = 0; i < 5; i++) begin
      hs(0, resp[i], 0, !resp[i]);
      if (i < 4) repeat (3) tick();
    end
    wait_ack(1'b0);

    // timeout: one write never answered
    hs(1, 0, 0, 0);
    req_pulse(DRAIN_TIMEOUT, 1'b1);
    wait_ack(1'b0);
    check("wr_after_timeout", int'(wr_out), 0);
    check("forced_sticky", int'(forced), 1);

    // boundaries: simultaneous inc/dec, underflow
    hs(1, 0, 0, 0);
    hs(1, 0, 0, 0);
    hs(1, 1, 0, 0);
    hs(0, 1, 0, 0);
    hs(0, 1, 0, 0);
    hs(0, 1, 0, 0);

    // random traffic followed by a request with no further responses
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 30; c++)
        hs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (wr_model == 0 && rd_model == 0) req_pulse(1, 1'b0);
      else req_pulse(DRAIN_TIMEOUT, 1'b1);
      wait_ack(1'b0);
    end

    // reset mid-sequence on the 5th RESET cycle
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    repeat (4) tick();
    check("in_reset_before_abort", int'(slv_rst_n), 0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("abort_slv_rst_n", int'(slv_rst_n), 1);
    check("abort_isolate", int'(isolate), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_counts", int'(wr_out) + int'(rd_out), 0);
    check("abort_forced", int'(forced), 0);
    check("abort_proto_err", int'(proto_err), 0);
    wr_model = 0; rd_model = 0; perr_model = 1'b0;

    // overflow on reads, then drain back to zero
    repeat (9) hs(0, 0, 1, 0);
    repeat (8) hs(0, 0, 0, 1);

    // held request: two sequences, then drop on the second ack
    exp_q.push_back({1'b0, 16'd1});
    exp_q.push_back({1'b0, 16'd1});
    rst_req = 1'b1;
    wait_ack(1'b0);
    check("idle_between", int'(busy), 0);
    wait_ack(1'b1);
    repeat (4) tick();
    check("stays_idle", int'(busy), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
